// File: rtl/cordic_tilt.sv
// cordic_tilt: pitch and roll tilt angles from a 3-axis accelerometer.
// A single CORDIC vectoring engine is reused across sequential phases:
// magnitude of the two "other" axes, then angle of (magnitude, numerator).
// Angle scale: 11790 LSB = 90 degrees.
// Optional feature macro: CORDIC_TILT_ROLL_EN
//   defined   -> phases P_MAG, P_ANG, R_MAG, R_ANG, DONE (roll computed)
//   undefined -> phases P_MAG, P_ANG, DONE; roll_angle tied to 0

module cordic_tilt #(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] az,
    output logic         busy,
    output logic         done,
    output logic [15:0]  pitch_angle,
    output logic [15:0]  roll_angle
);

    localparam int DW = W + 3;
    localparam int ZW = 18;
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(ITER);
    localparam logic signed [ZW-1:0] ANG_MAX  = 18'sd11790;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_MAG,
        S_P_ANG,
        S_R_MAG,
        S_R_ANG,
        S_DONE
    } state_t;

    // atan(2^-i) in angle LSBs
    function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
        logic signed [ZW-1:0] v;
        v = '0;
        case (int'(idx))
            0:       v = 18'sd5895;
            1:       v = 18'sd3480;
            2:       v = 18'sd1839;
            3:       v = 18'sd933;
            4:       v = 18'sd468;
            5:       v = 18'sd234;
            6:       v = 18'sd117;
            7:       v = 18'sd59;
            8:       v = 18'sd29;
            9:       v = 18'sd15;
            10:      v = 18'sd7;
            11:      v = 18'sd4;
            12:      v = 18'sd2;
            13:      v = 18'sd1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Multiply by ~1/K (0.6074) to remove the CORDIC gain from a magnitude
    function automatic logic signed [DW-1:0] scale_inv_k(input logic signed [DW-1:0] x);
        return (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    endfunction

    // Clamp the accumulated angle to +/-90 degrees
    function automatic logic [15:0] sat_angle(input logic signed [ZW-1:0] z);
        logic signed [ZW-1:0] c;
        if (z > ANG_MAX)
            c = ANG_MAX;
        else if (z < -ANG_MAX)
            c = -ANG_MAX;
        else
            c = z;
        return 16'(c);
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_idx;
    logic                 w_last;
    logic signed [W-1:0]  r_ax, r_ay, r_az;
    logic signed [DW-1:0] r_x, r_y;
    logic signed [ZW-1:0] r_z;
    logic                 r_num_zero;
    logic [15:0]          r_pitch_angle;
`ifdef CORDIC_TILT_ROLL_EN
    logic [15:0]          r_roll_angle;
    logic [15:0]          r_pitch_hold;
`endif

    logic                 w_is_ang;
    logic signed [W-1:0]  w_mag_b;
    logic signed [W-1:0]  w_num;
    logic signed [W:0]    w_az_ext, w_az_abs;
    logic signed [DW-1:0] w_x_load, w_y_load;
    logic signed [DW-1:0] w_sh_x, w_sh_y, w_x_it, w_y_it;
    logic signed [ZW-1:0] w_atan, w_z_it;
    logic                 w_y_neg;
    logic [15:0]          w_ang_res;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state: each CORDIC phase lasts one load cycle plus ITER iterations
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_P_MAG;
            S_P_MAG: if (w_last) w_state_nxt = S_P_ANG;
`ifdef CORDIC_TILT_ROLL_EN
            S_P_ANG: if (w_last) w_state_nxt = S_R_MAG;
            S_R_MAG: if (w_last) w_state_nxt = S_R_ANG;
            S_R_ANG: if (w_last) w_state_nxt = S_DONE;
`else
            S_P_ANG: if (w_last) w_state_nxt = S_DONE;
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Per-phase operand selection: MAG phases take (|az|, b), ANG phases
    // take (magnitude, numerator)
    always_comb begin
        w_is_ang = 1'b0;
        w_mag_b  = r_ay;
        w_num    = r_ax;
        case (r_state)
            S_P_ANG: w_is_ang = 1'b1;
`ifdef CORDIC_TILT_ROLL_EN
            S_R_MAG: w_mag_b  = r_ax;
            S_R_ANG: begin
                w_is_ang = 1'b1;
                w_num    = r_ay;
            end
`endif
            default: ;
        endcase
    end

    // Load values and one vectoring micro-rotation
    always_comb begin
        w_last   = (r_cnt == CNT_LAST);
        w_idx    = r_cnt - CW'(1);
        // One extra bit so |-2^(W-1)| is representable
        w_az_ext = {r_az[W-1], r_az};
        w_az_abs = r_az[W-1] ? -w_az_ext : w_az_ext;
        w_x_load = w_is_ang ? scale_inv_k(r_x) : {{(DW-W-1){w_az_abs[W]}}, w_az_abs};
        w_y_load = w_is_ang ? {{3{w_num[W-1]}}, w_num} : {{3{w_mag_b[W-1]}}, w_mag_b};
        w_sh_x   = r_x >>> w_idx;
        w_sh_y   = r_y >>> w_idx;
        w_atan   = atan_lut(w_idx);
        w_y_neg  = r_y[DW-1];
        w_x_it   = w_y_neg ? r_x - w_sh_y : r_x + w_sh_y;
        w_y_it   = w_y_neg ? r_y + w_sh_x : r_y - w_sh_x;
        w_z_it   = w_y_neg ? r_z - w_atan : r_z + w_atan;
        // atan2(0, d) is exactly 0 for any d >= 0, including d = 0
        w_ang_res = r_num_zero ? 16'd0 : sat_angle(w_z_it);
    end

    // CORDIC datapath: latch axes on accept, then load/iterate per phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ax       <= '0;
            r_ay       <= '0;
            r_az       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_cnt      <= '0;
            r_num_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_ax <= ax;
                        r_ay <= ay;
                        r_az <= az;
                    end
                end
                S_P_MAG, S_P_ANG, S_R_MAG, S_R_ANG: begin
                    if (r_cnt == '0) begin
                        r_x        <= w_x_load;
                        r_y        <= w_y_load;
                        r_z        <= '0;
                        r_num_zero <= (w_num == '0);
                    end else begin
                        r_x <= w_x_it;
                        r_y <= w_y_it;
                        r_z <= w_z_it;
                    end
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Result registers: outputs change only on the edge into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pitch_angle <= '0;
`ifdef CORDIC_TILT_ROLL_EN
            r_roll_angle  <= '0;
            r_pitch_hold  <= '0;
`endif
        end else if (w_last) begin
            case (r_state)
`ifdef CORDIC_TILT_ROLL_EN
                S_P_ANG: r_pitch_hold <= w_ang_res;
                S_R_ANG: begin
                    r_pitch_angle <= r_pitch_hold;
                    r_roll_angle  <= w_ang_res;
                end
`else
                S_P_ANG: r_pitch_angle <= w_ang_res;
`endif
                default: ;
            endcase
        end
    end

    assign pitch_angle = r_pitch_angle;
`ifdef CORDIC_TILT_ROLL_EN
    assign roll_angle  = r_roll_angle;
`else
    assign roll_angle  = 16'd0;
`endif

endmodule

// File: doc/cordic_tilt.md
CORDIC_TILT -- requirements
Module: cordic_tilt

Interface
REQ-001 Parameter W, default 16, signed accelerometer input width (12..24).
REQ-002 Parameter ITER, default 16, CORDIC iterations per phase (8..16).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 ax, ay, az  input  W each  signed accelerometer axes.
REQ-007 busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-008 done  output  1  one-cycle pulse; pitch_angle/roll_angle valid from that cycle.
REQ-009 pitch_angle  output  16 signed  atan2(ax, sqrt(ay^2+az^2)).
REQ-010 roll_angle  output  16 signed  atan2(ay, sqrt(ax^2+az^2)).

Function
REQ-011 Angle scale: 11790 LSB = 90 deg (131 LSB/deg); outputs span [-11790, +11790].
REQ-012 atan table entry i = round(atan(2^-i) * 11790 / (pi/2)); entry 0 = 5895; ITER entries.
REQ-013 Start accepted in IDLE when start=1; ax/ay/az latched that cycle; inputs ignored afterwards.
REQ-014 start while busy is ignored; no queuing.
REQ-015 Phases, each 1 load cycle + ITER iteration cycles: P_MAG, P_ANG, R_MAG, R_ANG, then DONE (1 cycle), then IDLE.
REQ-016 MAG phase: vectoring on (|a|, b); result x scaled by 1/K via (x>>1)+(x>>3)-(x>>6)-(x>>9) in the next phase's load cycle.
REQ-017 P_MAG uses (az, ay); R_MAG uses (az, ax).
REQ-018 ANG phase: vectoring on (magnitude, numerator), numerator ax for pitch, ay for roll; z accumulates angle.
REQ-019 Vectoring rule: y>=0 -> x+=y>>>i, y-=x>>>i, z+=atan[i]; else opposite signs; arithmetic shifts.
REQ-020 Internal x/y datapath W+3 bits signed; no overflow for any input including -2^(W-1) on all axes.
REQ-021 Angle accumulator 18 bits signed; final value saturated to [-11790, +11790] into 16-bit output.
REQ-022 done asserted exactly 4*(ITER+1)+1 cycles after accept cycle (ITER=16: cycle 69).
REQ-023 Outputs update only in done cycle; hold until next done.
REQ-024 Zero denominator and zero numerator -> angle 0; zero denominator, numerator >0 -> +11790, <0 -> -11790 (within tolerance).
REQ-025 Accuracy: |error| <= 4 LSB vs ideal for ITER=16, all inputs.
REQ-026 start in DONE cycle is ignored; start in the following IDLE cycle is accepted.

Reset
REQ-027 rst=1 at any state, including mid-phase, forces IDLE next cycle.
REQ-028 Reset values: busy=0, done=0, pitch_angle=0, roll_angle=0, internal registers 0.
REQ-029 start during rst cycle is not accepted.

Configuration
REQ-030 Macro CORDIC_TILT_ROLL_EN defined: R_MAG/R_ANG phases compiled in, latency per REQ-022.
REQ-031 Macro undefined: roll phases and logic removed; roll_angle constant 0; sequence P_MAG, P_ANG, DONE; done at 2*(ITER+1)+1 cycles (ITER=16: cycle 35).

Verification
REQ-032 ax=11, ay=258, az=16068, start -> pitch_angle 5 +/-4, roll_angle 120 +/-4, done at cycle 69.
REQ-033 ax=-16384, ay=0, az=16384 -> pitch_angle -5895 +/-4, roll_angle 0 +/-4.
REQ-034 ax=16384, ay=0, az=0 -> pitch_angle 11790 +/-4 (saturation limit respected), roll_angle 0 +/-4.
REQ-035 ax=-32768, ay=32767, az=-32768 -> pitch_angle -4620 +/-4, no wrap; all-zero inputs -> both 0.
REQ-036 start pulsed at cycle 10 of a run -> ignored, single done; rst at cycle 30 -> busy=0, done never pulses, outputs 0.
REQ-037 Build without CORDIC_TILT_ROLL_EN, first vector -> pitch_angle 5 +/-4, roll_angle 0, done at cycle 35.
